hv_bist_ctrl: RTL and testbench

- Top-level BIST sequencer for the HV die. Runs analog BIST first, then logic BIST.
- Starts on a request and drives the enable of the analog BIST engine, which sits immediately downstream.
- Consumes the engine's six per-item statuses and its "analog done / start LBIST" flag, then runs a one-shot LBIST handshake.
- Supervises both phases with timeouts and publishes a sticky done/fail result with a fail code for the register bank and fault logic.

---
 rtl/hv_bist_pkg.sv | 31 +++
 rtl/hv_bist_ctrl_if.sv | 31 +++
 rtl/hv_bist_tmr.sv | 34 +++
 rtl/hv_bist_ctrl.sv | 123 ++++++++++++
 tb/tb_hv_bist_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/hv_bist_pkg.sv
// Shared types and constants for the HV die BIST sequencer and the analog BIST engine.
package hv_bist_pkg;

    localparam int ITEM_NUM = 6;
    localparam int FC_W     = ITEM_NUM + 2;

    // Fail-code bit positions above the per-item field
    localparam int FC_ABIST_TMO = 6;
    localparam int FC_LBIST     = 7;

    localparam int ITEM_OV     = 0;
    localparam int ITEM_OT     = 1;
    localparam int ITEM_OPSCOD = 2;
    localparam int ITEM_OC     = 3;
    localparam int ITEM_SC     = 4;
    localparam int ITEM_ADC    = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ABIST = 2'd1,
        LBIST = 2'd2,
        DONE  = 2'd3
    } bist_st_e;

    function automatic int tmr_width(input int abist_us, input int lbist_us, input int clk_m);
        int max_us;
        max_us = (abist_us > lbist_us) ? abist_us : lbist_us;
        return $clog2(max_us * clk_m + 1);
    endfunction

endpackage

// File: rtl/hv_bist_ctrl_if.sv
// Request, analog-engine and LBIST handshake signals of the BIST sequencer.
interface hv_bist_ctrl_if import hv_bist_pkg::*; ();

    logic                i_bist_req;
    logic                i_bist_clr;
    logic                o_bist_en;
    logic                i_abist_done;
    logic [ITEM_NUM-1:0] i_abist_status;
    logic                o_lbist_start;
    logic                i_lbist_done;
    logic                i_lbist_pass;
    logic                o_bist_busy;
    logic                o_bist_done;
    logic                o_bist_fail;
    logic [FC_W-1:0]     o_bist_fail_code;

    modport slave (
        input  i_bist_req, i_bist_clr, i_abist_done, i_abist_status,
               i_lbist_done, i_lbist_pass,
        output o_bist_en, o_lbist_start, o_bist_busy, o_bist_done,
               o_bist_fail, o_bist_fail_code
    );

    modport master (
        output i_bist_req, i_bist_clr, i_abist_done, i_abist_status,
               i_lbist_done, i_lbist_pass,
        input  o_bist_en, o_lbist_start, o_bist_busy, o_bist_done,
               o_bist_fail, o_bist_fail_code
    );

endinterface

// File: rtl/hv_bist_tmr.sv
// Saturating phase timer with synchronous clear and a terminal-count compare.
module hv_bist_tmr #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic [W-1:0] limit_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == limit_i);

endmodule

// File: rtl/hv_bist_ctrl.sv
// HV die BIST sequencer: analog BIST, then a one-shot LBIST handshake, both under timeout,
// ending in a sticky done/fail result with a fail code.
module hv_bist_ctrl import hv_bist_pkg::*; #(
    parameter int CLK_M        = 48,
    parameter int ABIST_TMO_US = 200,
    parameter int LBIST_TMO_US = 100
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    hv_bist_ctrl_if.slave  bus
);

    localparam int TMR_W = tmr_width(ABIST_TMO_US, LBIST_TMO_US, CLK_M);
    localparam logic [TMR_W-1:0] ABIST_LIM = TMR_W'(ABIST_TMO_US * CLK_M - 1);
    localparam logic [TMR_W-1:0] LBIST_LIM = TMR_W'(LBIST_TMO_US * CLK_M - 1);

    bist_st_e        state_q, state_d;
    logic            req_q;
    logic [FC_W-1:0] code_q, code_d;
    logic            en_q, en_d;
    logic            start_q, start_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            fail_q, fail_d;

    logic             req_rise;
    logic             tmr_clr;
    logic             tmr_tc;
    logic [TMR_W-1:0] tmr_lim;

    assign req_rise = bus.i_bist_req & ~req_q;
    assign tmr_clr  = (state_d != state_q);
    assign tmr_lim  = (state_q == ABIST) ? ABIST_LIM : LBIST_LIM;

    hv_bist_tmr #(.W(TMR_W)) u_tmr (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .clr_i   (tmr_clr),
        .limit_i (tmr_lim),
        .tc_o    (tmr_tc)
    );

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;

        unique case (state_q)
            IDLE: begin
                if (req_rise) state_d = ABIST;
            end
            ABIST: begin
                if (bus.i_bist_clr) begin
                    state_d = IDLE;
                    code_d  = '0;
                end else if (bus.i_abist_done) begin
                    code_d[ITEM_NUM-1:0] = bus.i_abist_status;
                    state_d              = LBIST;
                end else if (tmr_tc) begin
                    code_d[ITEM_NUM-1:0]  = bus.i_abist_status;
                    code_d[FC_ABIST_TMO]  = 1'b1;
                    state_d               = DONE;
                end
            end
            LBIST: begin
                // The start pulse marks the first cycle, where a stale done level is ignored
                if (bus.i_bist_clr) begin
                    state_d = IDLE;
                    code_d  = '0;
                end else if (!start_q && bus.i_lbist_done) begin
                    code_d[FC_LBIST] = ~bus.i_lbist_pass;
                    state_d          = DONE;
                end else if (tmr_tc) begin
                    code_d[FC_LBIST] = 1'b1;
                    state_d          = DONE;
                end
            end
            DONE: begin
                if (bus.i_bist_clr) begin
                    state_d = IDLE;
                    code_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        en_d    = (state_d inside {ABIST, LBIST});
        busy_d  = (state_d inside {ABIST, LBIST});
        start_d = (state_d == LBIST) && (state_q != LBIST);
        done_d  = (state_d == DONE);
        fail_d  = |code_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            code_q  <= '0;
            en_q    <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= bus.i_bist_req;
            code_q  <= code_d;
            en_q    <= en_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
        end
    end

    assign bus.o_bist_en        = en_q;
    assign bus.o_lbist_start    = start_q;
    assign bus.o_bist_busy      = busy_q;
    assign bus.o_bist_done      = done_q;
    assign bus.o_bist_fail      = fail_q;
    assign bus.o_bist_fail_code = code_q;

endmodule

// File: tb/tb_hv_bist_ctrl.sv
// Directed and randomized runs of hv_bist_ctrl against a phase-level timing/result model.
module tb_hv_bist_ctrl;
    import hv_bist_pkg::*;

    localparam int CLK_M         = 48;
    localparam int ABIST_TMO_US  = 200;
    localparam int LBIST_TMO_US  = 100;
    localparam int ABIST_TMO_CYC = ABIST_TMO_US * CLK_M;
    localparam int LBIST_TMO_CYC = LBIST_TMO_US * CLK_M;
    localparam int BOUND         = 20000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    hv_bist_ctrl_if bus();

    hv_bist_ctrl #(
        .CLK_M        (CLK_M),
        .ABIST_TMO_US (ABIST_TMO_US),
        .LBIST_TMO_US (LBIST_TMO_US)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Result code from the three outcomes of a run
    function automatic logic [7:0] model_code(input logic [5:0] items, input bit abist_tmo,
                                              input bit lbist_fail);
        return 8'(items) + (abist_tmo ? 8'h40 : 8'h00) + (lbist_fail ? 8'h80 : 8'h00);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "/en"},    32'(bus.o_bist_en),        0);
        check({tag, "/start"}, 32'(bus.o_lbist_start),    0);
        check({tag, "/busy"},  32'(bus.o_bist_busy),      0);
        check({tag, "/done"},  32'(bus.o_bist_done),      0);
        check({tag, "/fail"},  32'(bus.o_bist_fail),      0);
        check({tag, "/code"},  32'(bus.o_bist_fail_code), 0);
    endtask

    // abist_at / lbist_at: phase cycle (0 = first) at which done is raised; -1 = never.
    task automatic bist_run(input string name, input int abist_at, input bit rand_status,
                            input logic [5:0] fixed_status, input int lbist_at, input bit pass);
        int         ac, lc, starts, exp_ac, exp_lc, eff;
        logic [5:0] drv;
        bit         abist_tmo, lbist_fail;
        logic [7:0] ec;

        bus.i_bist_req = 1'b0;
        tick();
        bus.i_bist_req = 1'b1;
        check({name, "/en_before_edge"}, 32'(bus.o_bist_en), 0);
        tick();
        check({name, "/en_abist"},   32'(bus.o_bist_en),   1);
        check({name, "/busy_abist"}, 32'(bus.o_bist_busy), 1);

        ac  = 0;
        drv = fixed_status;
        do begin
            drv                 = rand_status ? 6'($urandom) : fixed_status;
            bus.i_abist_status  = drv;
            bus.i_abist_done    = (ac == abist_at);
            tick();
            ac++;
        end while (!bus.o_lbist_start && !bus.o_bist_done && ac < BOUND);
        bus.i_abist_done = 1'b0;

        abist_tmo = !(abist_at >= 0 && abist_at < ABIST_TMO_CYC);
        exp_ac    = abist_tmo ? ABIST_TMO_CYC : abist_at + 1;
        check({name, "/abist_cycles"}, 32'(ac), 32'(exp_ac));
        check({name, "/start_pulse"}, 32'(bus.o_lbist_start), abist_tmo ? 0 : 1);

        lbist_fail = 1'b0;
        if (!abist_tmo) begin
            lc     = 0;
            starts = 0;
            do begin
                bus.i_lbist_done = (lbist_at >= 0 && lc >= lbist_at);
                bus.i_lbist_pass = pass;
                tick();
                lc++;
                if (bus.o_lbist_start) starts++;
            end while (!bus.o_bist_done && lc < BOUND);
            bus.i_lbist_done = 1'b0;

            eff = (lbist_at < 1) ? 1 : lbist_at;
            if (lbist_at >= 0 && eff < LBIST_TMO_CYC) begin
                exp_lc     = eff + 1;
                lbist_fail = !pass;
            end else begin
                exp_lc     = LBIST_TMO_CYC;
                lbist_fail = 1'b1;
            end
            check({name, "/lbist_cycles"}, 32'(lc), 32'(exp_lc));
            check({name, "/extra_starts"}, 32'(starts), 0);
        end

        ec = model_code(drv, abist_tmo, lbist_fail);
        check({name, "/done"}, 32'(bus.o_bist_done),      1);
        check({name, "/code"}, 32'(bus.o_bist_fail_code), 32'(ec));
        check({name, "/fail"}, 32'(bus.o_bist_fail),      32'(|ec));
        check({name, "/en"},   32'(bus.o_bist_en),        0);
        check({name, "/busy"}, 32'(bus.o_bist_busy),      0);

        for (int i = 0; i < 3; i++) begin
            bus.i_abist_status = 6'($urandom);
            bus.i_lbist_done   = 1'($urandom);
            bus.i_abist_done   = 1'($urandom);
            tick();
        end
        bus.i_abist_done = 1'b0;
        bus.i_lbist_done = 1'b0;
        check({name, "/code_hold"}, 32'(bus.o_bist_fail_code), 32'(ec));
        check({name, "/done_hold"}, 32'(bus.o_bist_done),      1);

        bus.i_bist_clr = 1'b1;
        tick();
        bus.i_bist_clr = 1'b0;
        check_all_zero({name, "/clr"});
        repeat (4) tick();
        check({name, "/held_req_no_restart"}, 32'(bus.o_bist_en), 0);
        bus.i_bist_req = 1'b0;
        tick();
    endtask

    initial begin
        bus.i_bist_req     = 1'b0;
        bus.i_bist_clr     = 1'b0;
        bus.i_abist_done   = 1'b0;
        bus.i_abist_status = '0;
        bus.i_lbist_done   = 1'b0;
        bus.i_lbist_pass   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_all_zero("post_reset_idle");

        // Clear pulses in IDLE do nothing
        bus.i_bist_clr = 1'b1;
        tick();
        bus.i_bist_clr = 1'b0;
        check_all_zero("idle_clr");

        bist_run("pass",      3800, 1'b0, 6'h00, 500, 1'b1);
        bist_run("item_fail", 10 + int'($urandom_range(0, 1990)), 1'b0, 6'b010100,
                 int'($urandom_range(1, 800)), 1'b1);
        bist_run("rand_a", int'($urandom_range(0, 3000)), 1'b1, 6'h00,
                 int'($urandom_range(0, 2000)), 1'($urandom));
        bist_run("rand_b", int'($urandom_range(0, 3000)), 1'b1, 6'h00,
                 int'($urandom_range(0, 2000)), 1'($urandom));
        bist_run("abist_tmo", -1, 1'b1, 6'h00, 0, 1'b1);
        bist_run("lbist_fail", int'($urandom_range(0, 1500)), 1'b0, 6'h00,
                 int'($urandom_range(1, 1500)), 1'b0);
        bist_run("lbist_tmo", 100, 1'b0, 6'h00, -1, 1'b1);
        bist_run("abist_edge", ABIST_TMO_CYC - 1, 1'b0, 6'h00, 10, 1'b1);
        bist_run("lbist_first", 20, 1'b0, 6'h21, 0, 1'b1);
        bist_run("lbist_edge", 5, 1'b0, 6'h00, LBIST_TMO_CYC - 1, 1'b1);

        // Clear during ABIST aborts the run
        bus.i_bist_req = 1'b1;
        tick();
        check("abort/en_running", 32'(bus.o_bist_en), 1);
        bus.i_abist_status = 6'h3F;
        repeat (100) tick();
        bus.i_bist_clr = 1'b1;
        tick();
        bus.i_bist_clr = 1'b0;
        check_all_zero("abort");
        repeat (3) tick();
        check("abort/no_restart", 32'(bus.o_bist_en), 0);
        bus.i_bist_req = 1'b0;
        tick();

        // Request rising edge wins over a simultaneous clear in IDLE
        bus.i_bist_req = 1'b1;
        bus.i_bist_clr = 1'b1;
        tick();
        bus.i_bist_clr = 1'b0;
        check("req_vs_clr/en", 32'(bus.o_bist_en), 1);
        bus.i_bist_clr = 1'b1;
        tick();
        bus.i_bist_clr = 1'b0;
        check("req_vs_clr/abort_en", 32'(bus.o_bist_en), 0);
        bus.i_bist_req = 1'b0;
        tick();

        // Asynchronous reset in the first LBIST cycle
        bus.i_bist_req = 1'b1;
        tick();
        repeat (30) tick();
        bus.i_abist_done = 1'b1;
        tick();
        bus.i_abist_done = 1'b0;
        check("rst_mid/start", 32'(bus.o_lbist_start), 1);
        check("rst_mid/en",    32'(bus.o_bist_en),     1);
        #2;
        rst_n          = 1'b0;
        bus.i_bist_req = 1'b0;
        #1;
        check_all_zero("rst_mid_async");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        check_all_zero("rst_mid_release");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
